// File: rtl/ddr_frame_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ddr_frame_writer                                             |
// | Description : Packs the dual-camera RGB565 pixel-pair stream into 256-bit  |
// |               beats, buffers them in a FIFO and writes them to a linear    |
// |               DDR3 frame buffer with fixed-length AXI write bursts.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rstn               DDR phy clock, synchronous active-low reset      |
// |   ddr_inited              DDR ready; gates new write bursts                |
// |   frame_start             1-cycle pulse marking a new frame                |
// |   pix_valid/pixel_1/_2    pixel pair input (cam1 / cam2, RGB565)           |
// |   axi_aw*                 write address channel (awready is the input)     |
// |   axi_wdata/wstrb/wready  write data channel; wready pops one beat         |
// |   frame_done              1-cycle pulse when the last burst of a frame ends|
// |   overflow                sticky, a packed beat was lost to a full FIFO    |
// +----------------------------------------------------------------------------+
module ddr_frame_writer #(
    parameter logic [27:0] BASE_ADDR    = 28'h0000000,
    parameter int          BURST_LEN    = 16,
    parameter int          FRAME_BURSTS = 7200,
    parameter int          FIFO_DEPTH   = 64
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         ddr_inited,
    input  logic         frame_start,
    input  logic         pix_valid,
    input  logic [15:0]  pixel_1,
    input  logic [15:0]  pixel_2,
    output logic [27:0]  axi_awaddr,
    output logic         axi_awuser_ap,
    output logic [3:0]   axi_awuser_id,
    output logic [3:0]   axi_awlen,
    output logic         axi_awvalid,
    input  logic         axi_awready,
    output logic [255:0] axi_wdata,
    output logic [31:0]  axi_wstrb,
    input  logic         axi_wready,
    output logic         frame_done,
    output logic         overflow
);

    localparam int          c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int          c_BEAT_W   = $clog2(BURST_LEN) + 1;
    localparam int          c_FB_W     = $clog2(FRAME_BURSTS) + 1;
    // One beat covers 8 x 32-bit address units.
    localparam logic [27:0] c_ADDR_INC = 28'(BURST_LEN * 8);

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_AW    = 2'd1;
    localparam logic [1:0]  c_ST_W     = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;

    logic [255:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W:0]      r_wr_ptr;
    logic [c_PTR_W:0]      r_rd_ptr;
    logic [c_PTR_W:0]      w_count;
    logic                  w_full;

    logic [223:0]          r_pack;
    logic [223:0]          w_pack_nxt;
    logic [2:0]            r_lane;
    logic [255:0]          w_beat;

    logic                  r_pend;
    logic [27:0]           r_addr;
    logic [c_FB_W-1:0]     r_burst_cnt;
    logic [c_BEAT_W-1:0]   r_beat_cnt;
    logic                  r_frame_done;
    logic                  r_overflow;

    logic                  w_flush;
    logic                  w_accept;
    logic                  w_push_beat;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_burst_done;
    logic                  w_frame_wrap;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_count      = r_wr_ptr - r_rd_ptr;
    assign w_full       = (w_count == (c_PTR_W+1)'(FIFO_DEPTH));

    // A pending frame start flushes only once the bus side is back in IDLE,
    // so a burst already committed always finishes with its own data.
    assign w_flush      = (r_state == c_ST_IDLE) && r_pend;
    assign w_accept     = pix_valid && !r_pend && !frame_start;
    assign w_push_beat  = w_accept && (r_lane == 3'd7);
    assign w_push       = w_push_beat && !w_full;
    assign w_pop        = (r_state == c_ST_W) && axi_wready;
    assign w_burst_done = w_pop && (r_beat_cnt == c_BEAT_W'(BURST_LEN - 1));
    assign w_frame_wrap = w_burst_done && (r_burst_cnt == c_FB_W'(FRAME_BURSTS - 1));

    // The 8th pixel goes straight into the top lane of the pushed beat.
    assign w_beat       = {pixel_2, pixel_1, r_pack};

    always_comb begin
        w_pack_nxt = r_pack;
        for (int k = 0; k < 7; k++) begin
            if (r_lane == 3'(k)) begin
                w_pack_nxt[32*k +: 32] = {pixel_2, pixel_1};
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (ddr_inited && !r_pend && !frame_start &&
                    (w_count >= (c_PTR_W+1)'(BURST_LEN))) begin
                    w_state_nxt = c_ST_AW;
                end
            end
            c_ST_AW: begin
                if (axi_awready) begin
                    w_state_nxt = c_ST_W;
                end
            end
            c_ST_W: begin
                if (w_burst_done) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Beat storage has no reset; the pointers define its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= w_beat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_pack       <= '0;
            r_lane       <= 3'd0;
            r_pend       <= 1'b0;
            r_addr       <= BASE_ADDR;
            r_burst_cnt  <= '0;
            r_beat_cnt   <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            if (frame_start) begin
                r_pend <= 1'b1;
            end

            if (w_accept) begin
                r_lane <= r_lane + 3'd1;
                r_pack <= w_pack_nxt;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (c_PTR_W+1)'(1);
            end
            if (w_push_beat && w_full) begin
                r_overflow <= 1'b1;
            end

            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + (c_PTR_W+1)'(1);
                r_beat_cnt <= w_burst_done ? '0 : r_beat_cnt + c_BEAT_W'(1);
            end

            if (w_burst_done) begin
                if (w_frame_wrap) begin
                    r_addr       <= BASE_ADDR;
                    r_burst_cnt  <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_addr       <= r_addr + c_ADDR_INC;
                    r_burst_cnt  <= r_burst_cnt + c_FB_W'(1);
                end
            end

            // Flush cannot coincide with push (pixels are dropped while
            // pending) or pop (only in IDLE), so it simply overrides.
            if (w_flush) begin
                r_rd_ptr    <= r_wr_ptr;
                r_lane      <= 3'd0;
                r_addr      <= BASE_ADDR;
                r_burst_cnt <= '0;
                r_overflow  <= 1'b0;
                r_pend      <= frame_start;
            end
        end
    end

    assign axi_awaddr    = r_addr;
    assign axi_awuser_ap = 1'b0;
    assign axi_awuser_id = 4'd0;
    assign axi_awlen     = 4'(BURST_LEN - 1);
    assign axi_awvalid   = (r_state == c_ST_AW);
    assign axi_wdata     = (r_state == c_ST_W) ? r_mem[r_rd_ptr[c_PTR_W-1:0]] : '0;
    assign axi_wstrb     = 32'hFFFF_FFFF;
    assign frame_done    = r_frame_done;
    assign overflow      = r_overflow;

endmodule
`default_nettype wire
